alu_inv_seq: RTL and testbench



---
 rtl/alu_inv_pkg.sv | 19 +
 rtl/alu_inv_seq_if.sv | 27 ++
 rtl/alu_inv_seq_div_step.sv | 24 ++
 rtl/alu_inv_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_inv_seq.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_inv_pkg.sv
// Shared definitions for the inverse-operation unit: op codes, FSM states, default width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_inv_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] OP_SUB      = 2'b00;
    localparam logic [1:0] OP_SHR      = 2'b01;
    localparam logic [1:0] OP_DIV      = 2'b10;
    localparam logic [1:0] OP_PASS_SRA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_inv_seq_if.sv
// Request/result bundle between the pipeline controller and the inverse-operation unit.
// Latency: n/a (wires only).
// Backpressure: start/busy/done handshake; requester holds off while busy is high.
interface alu_inv_seq_if import alu_inv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rem;
    logic             zero;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  out, rem, zero, div_by_zero, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output out, rem, zero, div_by_zero, busy, done
    );
endinterface

// File: rtl/alu_inv_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
module div_step import alu_inv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dbit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;

    // Partial remainder is one bit wider than the divisor; when it is >= divisor the
    // difference is below the divisor, so the low WIDTH bits of the subtraction suffice.
    always_comb begin
        partial = {rem_i, dbit_i};
        diff    = partial[WIDTH-1:0] - divisor_i;
        qbit_o  = (partial >= {1'b0, divisor_i});
        rem_o   = qbit_o ? diff : partial[WIDTH-1:0];
    end
endmodule

// File: rtl/alu_inv_seq.sv
// Multi-cycle inverse ALU (SUB, SHR, restoring DIV, op 11 = PASS or SRA when ALU_INV_SRA_EN is defined).
// Latency: start sampled at edge N, done pulses after edge N+1+k (k = iterations for the op).
// Backpressure: busy high while working; start ignored (not queued) unless idle; result held until next done.
module alu_inv_seq import alu_inv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic          clk,
    input logic          rst_n,
    alu_inv_seq_if.slave bus
);
    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] out_q, rem_q;
    logic             zero_q, dbz_q, done_q;

    logic             accept;
    logic [CNT_W-1:0] shr_k;
    logic [CNT_W-1:0] k_acc;
    logic             fill;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] res_out, res_rem;
    logic             res_dbz;

    assign accept = (state_q == S_IDLE) && bus.start;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (r_q),
        .dbit_i    (w_q[WIDTH-1]),
        .divisor_i (b_q),
        .rem_o     (step_rem),
        .qbit_o    (step_q)
    );

    // Iteration count for the incoming request; shifts saturate at WIDTH.
    always_comb begin
        shr_k = (bus.b >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(bus.b);
        k_acc = '0;
        case (bus.op)
            OP_SHR:      k_acc = shr_k;
            OP_DIV:      k_acc = (bus.b == '0) ? '0 : CNT_W'(WIDTH);
`ifdef ALU_INV_SRA_EN
            OP_PASS_SRA: k_acc = shr_k;
`endif
            default:     k_acc = '0;
        endcase
    end

    // FSM next state: zero-iteration ops skip RUN and go straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = (k_acc != '0) ? S_RUN : S_DONE;
            S_RUN:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next state: latch operands on accept, then one shift or divide step per RUN cycle.
    always_comb begin
        op_d  = op_q;
        w_d   = w_q;
        b_d   = b_q;
        r_d   = r_q;
        cnt_d = cnt_q;
        fill  = 1'b0;
`ifdef ALU_INV_SRA_EN
        if (op_q == OP_PASS_SRA) fill = w_q[WIDTH-1];
`endif
        if (accept) begin
            op_d  = bus.op;
            w_d   = bus.a;
            b_d   = bus.b;
            r_d   = '0;
            cnt_d = k_acc;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == OP_DIV) begin
                // w_q shifts dividend bits out of the top while quotient bits enter at the bottom.
                w_d = {w_q[WIDTH-2:0], step_q};
                r_d = step_rem;
            end else begin
                w_d = {fill, w_q[WIDTH-1:1]};
            end
        end
    end

    // Final result selection, consumed on the DONE transition.
    always_comb begin
        res_out = w_q;
        res_rem = '0;
        res_dbz = 1'b0;
        case (op_q)
            OP_SUB: res_out = w_q - b_q;
            OP_DIV: begin
                if (b_q == '0) begin
                    res_out = '1;
                    res_rem = w_q;
                    res_dbz = 1'b1;
                end else begin
                    res_out = w_q;
                    res_rem = r_q;
                end
            end
            default: res_out = w_q;
        endcase
    end

    // State and working registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_SUB;
            w_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            w_q     <= w_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers: update only when leaving DONE; div_by_zero clears on each accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            rem_q  <= '0;
            zero_q <= 1'b1;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                out_q  <= res_out;
                rem_q  <= res_rem;
                zero_q <= (res_out == '0);
                dbz_q  <= res_dbz;
            end else if (accept) begin
                dbz_q  <= 1'b0;
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.rem         = rem_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_inv_seq.sv
// Scoreboard bench for alu_inv_seq: directed cases plus random ops against an arithmetic model.
// Latency: expects done exactly 1+k cycles after the accepting edge.
// Backpressure: issues only when idle; probes ignored start while busy and reset abort.
module tb_alu_inv_seq;
    import alu_inv_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_inv_seq_if #(.WIDTH(W)) bus ();

    alu_inv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] o;
        logic [7:0] r;
        logic       z;
        logic       dz;
        int         n;
        int         lat;
        int         id;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       me;
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         next_id = 0;
    logic [7:0] last_out = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model straight from the operation definitions.
    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   kk;
        int   sa;
        e.r  = 8'h00;
        e.dz = 1'b0;
        kk   = 0;
        case (op)
            2'd0: e.o = a - b;
            2'd1: begin
                kk  = (int'(b) > 8) ? 8 : int'(b);
                e.o = (int'(b) >= 8) ? 8'h00 : (a >> b);
            end
            2'd2: begin
                if (b == 8'h00) begin
                    e.o = 8'hFF; e.r = a; e.dz = 1'b1;
                end else begin
                    e.o = a / b; e.r = a % b; kk = 8;
                end
            end
            default: begin
`ifdef ALU_INV_SRA_EN
                kk  = (int'(b) > 8) ? 8 : int'(b);
                sa  = int'($signed(a));
                e.o = 8'(sa >>> kk);
`else
                sa  = 0;
                e.o = a + 8'(sa);
`endif
            end
        endcase
        e.z   = (e.o == 8'h00);
        e.lat = 1 + kk;
        e.n   = 0;
        e.id  = 0;
        return e;
    endfunction

    // Monitor: every done pops one expectation and checks value and latency.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                me = sb_q.pop_front();
                chk($sformatf("op%0d_out", me.id),  bus.out,         me.o);
                chk($sformatf("op%0d_rem", me.id),  bus.rem,         me.r);
                chk($sformatf("op%0d_zero", me.id), bus.zero,        me.z);
                chk($sformatf("op%0d_dbz", me.id),  bus.div_by_zero, me.dz);
                chk($sformatf("op%0d_lat", me.id),  cyc - me.n,      me.lat);
                last_out = me.o;
            end
        end
    end

    function automatic exp_t expect_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                       input int n);
        exp_t e;
        e    = model(op, a, b);
        e.n  = n;
        e.id = next_id;
        next_id++;
        return e;
    endfunction

    // Called just after a rising edge with the DUT idle; start is sampled on the next edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        sb_q.push_back(expect_op(op, a, b, cyc + 1));
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        @(negedge clk);
        chk("busy_after_accept", bus.busy, 1'b1);
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (sb_q.size() != 0 && i < 60);
        #1;
        if (sb_q.size() != 0) begin
            chk("done_timeout", 32'd1, 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out"},  bus.out,         8'h00);
        chk({tag, "_rem"},  bus.rem,         8'h00);
        chk({tag, "_zero"}, bus.zero,        1'b1);
        chk({tag, "_dbz"},  bus.div_by_zero, 1'b0);
        chk({tag, "_busy"}, bus.busy,        1'b0);
        chk({tag, "_done"}, bus.done,        1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rop;
        logic [7:0] ra, rb;

        rst_n = 1'b0; bus.start = 1'b0; bus.op = 2'd0; bus.a = 8'h00; bus.b = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        issue(OP_SUB, 8'h05, 8'h07);       wait_done();
        issue(OP_SHR, 8'hB4, 8'd3);        wait_done();
        issue(OP_SHR, 8'hB4, 8'd9);        wait_done();
        issue(OP_DIV, 8'd200, 8'd7);       wait_done();
        issue(OP_DIV, 8'h3C, 8'h00);       wait_done();
        issue(OP_PASS_SRA, 8'h90, 8'd2);   wait_done();

        // Result must hold through idle.
        repeat (3) @(negedge clk);
        chk("hold_out", bus.out, last_out);
        @(posedge clk); #1;

        // Start pulsed during RUN is ignored and not queued.
        issue(OP_DIV, 8'd200, 8'd7);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_SUB; bus.a = 8'h01; bus.b = 8'h01;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_after_ignored", bus.busy, 1'b0);
        @(posedge clk); #1;

        // Continuous start: second accept two edges after the first for a k=0 op.
        sb_q.push_back(expect_op(OP_SUB, 8'h10, 8'h01, cyc + 1));
        sb_q.push_back(expect_op(OP_SUB, 8'h10, 8'h01, cyc + 3));
        bus.start = 1'b1; bus.op = OP_SUB; bus.a = 8'h10; bus.b = 8'h01;
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done();

        // Reset mid-divide aborts: no done, outputs back to reset values.
        issue(OP_DIV, 8'hAB, 8'h05);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_reset_vals("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Randomized ops.
        for (int t = 0; t < 40; t++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            issue(rop, ra, rb);
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
